// File: rtl/axi_mem_limiter_pkg.sv
// Shared AXI parameters for the memory-port outstanding-burst limiter.
package axi_mem_limiter_pkg;
  localparam int AXI_DATA_W  = 64;
  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_MAX_OUT = 8;
  localparam int CNT_W       = 4;
  localparam int STALL_W     = 32;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  function automatic logic cnt_stall(input logic valid, input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] max);
    return valid && (cnt == max);
  endfunction
endpackage

// File: rtl/axi_mem_limiter_counter.sv
// Saturating up/down burst counter with a sticky underflow flag, plus its checker.
module axi_burst_counter
  import axi_mem_limiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         full,
  output logic         err
);
  logic [W-1:0] count_r;
  logic         err_r;

  // Count open bursts; a retire with nothing open holds at zero and latches err
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        2'b01: begin
          if (count_r == {W{1'b0}}) begin
            err_r <= 1'b1;
          end else begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
          end
        end
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign full  = (count_r >= max);
  assign err   = err_r;
endmodule

module axi_burst_counter_chk (
  input logic clk,
  input logic rst,
  input logic inc,
  input logic dec,
  input logic full,
  input logic err
);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !err);
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(full && inc && !dec));
endmodule

// File: rtl/axi_mem_limiter.sv
// Limits open AXI read/write bursts to MAX_OUT per direction; payloads pass through untouched.
module axi_mem_limiter
  import axi_mem_limiter_pkg::*;
#(
  parameter int DATA_W  = AXI_DATA_W,
  parameter int ID_W    = AXI_ID_W,
  parameter int ADDR_W  = AXI_ADDR_W,
  parameter int MAX_OUT = AXI_MAX_OUT
) (
  input  logic                uncoreclk,
  input  logic                uncorerst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [CNT_W-1:0]    rd_outstanding,
  output logic [CNT_W-1:0]    wr_outstanding,
  output logic [STALL_W-1:0]  stall_cnt
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0]   rd_cnt_s, wr_cnt_s, wd_cnt_s;
  logic               rd_full_s, wr_full_s, wd_full_s;
  logic               rd_err_s, wr_err_s, wd_err_s;
  logic               run_s, ar_ok_s, aw_ok_s, w_open_s;
  logic               ar_hs_s, r_done_s, aw_hs_s, w_done_s, b_hs_s;
  logic [STALL_W-1:0] stall_r;

  assign run_s   = ~uncorerst;
  assign ar_ok_s = run_s & ~rd_full_s;
  assign aw_ok_s = run_s & ~wr_full_s;

  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_arvalid = s_axi_arvalid & ar_ok_s;
  assign s_axi_arready = m_axi_arready & ar_ok_s;

  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast;
  assign s_axi_rvalid = m_axi_rvalid & run_s;
  assign m_axi_rready = s_axi_rready & run_s;

  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awvalid = s_axi_awvalid & aw_ok_s;
  assign s_axi_awready = m_axi_awready & aw_ok_s;

  // W may only run against an address already accepted or being accepted now
  assign w_open_s     = run_s & ((wd_cnt_s != {CNT_W{1'b0}}) | aw_hs_s);
  assign m_axi_wdata  = s_axi_wdata;
  assign m_axi_wstrb  = s_axi_wstrb;
  assign m_axi_wlast  = s_axi_wlast;
  assign m_axi_wvalid = s_axi_wvalid & w_open_s;
  assign s_axi_wready = m_axi_wready & w_open_s;

  assign s_axi_bid    = m_axi_bid;
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_bvalid = m_axi_bvalid & run_s;
  assign m_axi_bready = s_axi_bready & run_s;

  assign ar_hs_s  = m_axi_arvalid & m_axi_arready;
  assign r_done_s = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign aw_hs_s  = m_axi_awvalid & m_axi_awready;
  assign w_done_s = m_axi_wvalid & m_axi_wready & m_axi_wlast;
  assign b_hs_s   = m_axi_bvalid & m_axi_bready;

  axi_burst_counter #(.W(CNT_W)) u_rd_cnt (
    .clk(uncoreclk), .rst(uncorerst), .inc(ar_hs_s), .dec(r_done_s), .max(MAX_C),
    .count(rd_cnt_s), .full(rd_full_s), .err(rd_err_s)
  );
  axi_burst_counter #(.W(CNT_W)) u_wr_cnt (
    .clk(uncoreclk), .rst(uncorerst), .inc(aw_hs_s), .dec(b_hs_s), .max(MAX_C),
    .count(wr_cnt_s), .full(wr_full_s), .err(wr_err_s)
  );
  axi_burst_counter #(.W(CNT_W)) u_wd_cnt (
    .clk(uncoreclk), .rst(uncorerst), .inc(aw_hs_s), .dec(w_done_s), .max(MAX_C),
    .count(wd_cnt_s), .full(wd_full_s), .err(wd_err_s)
  );

  axi_burst_counter_chk u_rd_chk (.clk(uncoreclk), .rst(uncorerst), .inc(ar_hs_s),
    .dec(r_done_s), .full(rd_full_s), .err(rd_err_s));
  axi_burst_counter_chk u_wr_chk (.clk(uncoreclk), .rst(uncorerst), .inc(aw_hs_s),
    .dec(b_hs_s), .full(wr_full_s), .err(wr_err_s));
  axi_burst_counter_chk u_wd_chk (.clk(uncoreclk), .rst(uncorerst), .inc(aw_hs_s),
    .dec(w_done_s), .full(wd_full_s), .err(wd_err_s));

  // Free-running count of cycles where an address request is held back by a full counter
  always_ff @(posedge uncoreclk) begin
    if (uncorerst) begin
      stall_r <= {STALL_W{1'b0}};
    end else if (cnt_stall(s_axi_arvalid, rd_cnt_s, MAX_C) |
                 cnt_stall(s_axi_awvalid, wr_cnt_s, MAX_C)) begin
      stall_r <= stall_r + {{(STALL_W-1){1'b0}}, 1'b1};
    end else begin
      stall_r <= stall_r;
    end
  end

  assign rd_outstanding = rd_cnt_s;
  assign wr_outstanding = wr_cnt_s;
  assign stall_cnt      = stall_r;
endmodule

// File: tb/tb_axi_mem_limiter.sv
// Directed bench for axi_mem_limiter with default parameters (MAX_OUT = 8).
module tb_axi_mem_limiter;
  logic uncoreclk = 1'b0;
  logic uncorerst;
  always #5 uncoreclk = ~uncoreclk;

  logic [3:0]  s_axi_awid, m_axi_awid, s_axi_bid, m_axi_bid, s_axi_arid, m_axi_arid, s_axi_rid, m_axi_rid;
  logic [31:0] s_axi_awaddr, m_axi_awaddr, s_axi_araddr, m_axi_araddr;
  logic [7:0]  s_axi_awlen, m_axi_awlen, s_axi_arlen, m_axi_arlen, s_axi_wstrb, m_axi_wstrb;
  logic [2:0]  s_axi_awsize, m_axi_awsize, s_axi_arsize, m_axi_arsize;
  logic [1:0]  s_axi_awburst, m_axi_awburst, s_axi_arburst, m_axi_arburst;
  logic [1:0]  s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
  logic [63:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
  logic s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic s_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
  logic s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [3:0]  rd_outstanding, wr_outstanding;
  logic [31:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  axi_mem_limiter dut (
    .uncoreclk(uncoreclk), .uncorerst(uncorerst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge uncoreclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    s_axi_awid = 4'h0; s_axi_awaddr = 32'h0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd3;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0;
    s_axi_wdata = 64'h0; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_arid = 4'h0; s_axi_araddr = 32'h0; s_axi_arlen = 8'd0; s_axi_arsize = 3'd3;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_bid = 4'h0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    m_axi_rid = 4'h0; m_axi_rdata = 64'h0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;

    // Reset forces handshakes low and clears state
    uncorerst = 1'b1; s_axi_arvalid = 1'b1; m_axi_rvalid = 1'b1;
    settle();
    chk("rst_m_arvalid", m_axi_arvalid, 64'd0);
    chk("rst_s_arready", s_axi_arready, 64'd0);
    chk("rst_s_rvalid", s_axi_rvalid, 64'd0);
    chk("rst_m_rready", m_axi_rready, 64'd0);
    step(); step();
    chk("rst_rd_out", rd_outstanding, 64'd0);
    chk("rst_wr_out", wr_outstanding, 64'd0);
    chk("rst_stall", stall_cnt, 64'd0);
    s_axi_arvalid = 1'b0; m_axi_rvalid = 1'b0; uncorerst = 1'b0;
    step();

    // Single read burst, len=3
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_1000; s_axi_arlen = 8'd3; s_axi_arid = 4'h5;
    settle();
    chk("a_m_arvalid", m_axi_arvalid, 64'd1);
    chk("a_s_arready", s_axi_arready, 64'd1);
    chk("a_araddr", m_axi_araddr, 64'h1000);
    chk("a_arid", m_axi_arid, 64'h5);
    step();
    s_axi_arvalid = 1'b0;
    chk("a_rd_out_open", rd_outstanding, 64'd1);
    for (int i = 0; i < 4; i++) begin
      m_axi_rvalid = 1'b1; m_axi_rdata = 64'hA0 + 64'(i); m_axi_rlast = (i == 3);
      settle();
      chk("a_rdata", s_axi_rdata, 64'hA0 + 64'(i));
      step();
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      chk("a_rd_out_beat", rd_outstanding, (i == 3) ? 64'd0 : 64'd1);
    end

    // Fill reads to MAX_OUT, stall the 9th, release with one rlast
    s_axi_arvalid = 1'b1; s_axi_arlen = 8'd0;
    repeat (8) step();
    chk("b_rd_full", rd_outstanding, 64'd8);
    settle();
    chk("b_s_arready_stall", s_axi_arready, 64'd0);
    chk("b_m_arvalid_stall", m_axi_arvalid, 64'd0);
    repeat (3) step();
    chk("b_stall3", stall_cnt, 64'd3);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    settle();
    chk("b_arready_same_cycle", s_axi_arready, 64'd0);
    step();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    settle();
    chk("b_stall4", stall_cnt, 64'd4);
    chk("b_rd_7", rd_outstanding, 64'd7);
    chk("b_arready_release", s_axi_arready, 64'd1);
    chk("b_arvalid_release", m_axi_arvalid, 64'd1);
    step();
    s_axi_arvalid = 1'b0;
    chk("b_rd_refill", rd_outstanding, 64'd8);
    step();
    chk("b_stall_hold", stall_cnt, 64'd4);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    repeat (8) step();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    chk("b_rd_drained", rd_outstanding, 64'd0);

    // W ahead of AW is held until the AW handshake
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1; s_axi_wdata = 64'hDEAD_BEEF;
    settle();
    chk("c_m_wvalid_blocked", m_axi_wvalid, 64'd0);
    chk("c_s_wready_blocked", s_axi_wready, 64'd0);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_2000;
    settle();
    chk("c_m_wvalid_pass", m_axi_wvalid, 64'd1);
    chk("c_s_wready_pass", s_axi_wready, 64'd1);
    chk("c_wdata", m_axi_wdata, 64'hDEAD_BEEF);
    chk("c_awaddr", m_axi_awaddr, 64'h2000);
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("c_wr_out", wr_outstanding, 64'd1);
    s_axi_wvalid = 1'b1;
    settle();
    chk("c_wd_retired", s_axi_wready, 64'd0);
    s_axi_wvalid = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bid = 4'h3; m_axi_bresp = 2'b10;
    settle();
    chk("c_s_bvalid", s_axi_bvalid, 64'd1);
    chk("c_bresp", s_axi_bresp, 64'd2);
    step();
    m_axi_bvalid = 1'b0;
    chk("c_wr_closed", wr_outstanding, 64'd0);

    // B retire and pending AW together at wr_cnt=MAX_OUT
    s_axi_awvalid = 1'b1;
    repeat (8) step();
    s_axi_awvalid = 1'b0;
    chk("d_wr_full", wr_outstanding, 64'd8);
    settle();
    chk("d_awready_full", s_axi_awready, 64'd0);
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
    settle();
    chk("d_w_credit", s_axi_wready, 64'd1);
    step();
    s_axi_wvalid = 1'b0;
    m_axi_bvalid = 1'b1; s_axi_awvalid = 1'b1;
    settle();
    chk("d_awready_b_cycle", s_axi_awready, 64'd0);
    step();
    m_axi_bvalid = 1'b0;
    settle();
    chk("d_awready_next", s_axi_awready, 64'd1);
    step();
    s_axi_awvalid = 1'b0;
    chk("d_wr_stays", wr_outstanding, 64'd8);
    chk("d_stall5", stall_cnt, 64'd5);

    // Reset mid-operation with rd_cnt=5, wd_cnt=2
    s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
    repeat (6) step();
    s_axi_wvalid = 1'b0;
    s_axi_arvalid = 1'b1;
    repeat (5) step();
    s_axi_arvalid = 1'b0;
    chk("e_rd_5", rd_outstanding, 64'd5);
    uncorerst = 1'b1; m_axi_rvalid = 1'b1; s_axi_wvalid = 1'b1;
    settle();
    chk("e_rst_s_rvalid", s_axi_rvalid, 64'd0);
    chk("e_rst_s_wready", s_axi_wready, 64'd0);
    step();
    uncorerst = 1'b0; m_axi_rvalid = 1'b0;
    chk("e_rd_cleared", rd_outstanding, 64'd0);
    chk("e_wr_cleared", wr_outstanding, 64'd0);
    chk("e_stall_cleared", stall_cnt, 64'd0);
    settle();
    chk("e_wd_cleared", s_axi_wready, 64'd0);
    s_axi_wvalid = 1'b0;
    s_axi_arvalid = 1'b1;
    settle();
    chk("e_ar_after_rst", s_axi_arready, 64'd1);
    s_axi_arvalid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
